// File: rtl/div_bus_sequencer_pkg.sv
// div_pkg: shared state encoding and constants for div_bus_sequencer.
// Imported by the sequencer top and its register module.
package div_pkg;

  localparam int DIV_W = 8;

  localparam logic [DIV_W-1:0] DIV0_QUOTIENT = 8'hFF;

  typedef enum logic [3:0] {
    IDLE,
    START,
    LOAD_A,
    LOAD_Q,
    LOAD_M,
    WAIT,
    CAP_R,
    CAP_Q,
    RESULT
  } div_seq_state_t;

endpackage

// File: rtl/div_bus_sequencer_reg.sv
// div_bus_sequencer_reg: loadable register with optional serial shift.
// Load has priority; async active-low clear.
module div_bus_sequencer_reg
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_en,
  input  logic         shift_en,
  input  logic         shift_in,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // parallel load, else shift left, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load_en) begin
      q <= d;
    end else if (shift_en) begin
      q <= {q[W-2:0], shift_in};
    end
  end

endmodule

// File: rtl/div_bus_sequencer.sv
// div_bus_sequencer: serialises A/Q/M onto the divider bus and captures R/Q.
// Optional divide-by-zero bypass: define DIVSEQ_DIV0_CHECK_EN.
module div_bus_sequencer
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_err,
  output logic              busy,
  output logic              div_enable,
  output logic [DATA_W-1:0] div_inbus,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_outbus
);

  div_seq_state_t state;

  logic              req_load;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] m_q;

  logic              rem_load;
  logic [DATA_W-1:0] rem_d;
  logic              quo_load;
  logic [DATA_W-1:0] quo_d;

`ifdef DIVSEQ_DIV0_CHECK_EN
  logic err_q;
  logic div0;
  assign div0    = (divisor == '0);
  assign div_err = err_q;
`else
  assign div_err = 1'b0;
`endif

  // in_ready is gated by rst_n so it reads 0 while reset is held
  assign in_ready = rst_n & (state == IDLE);
  assign busy     = (state != IDLE);
  assign req_load = (state == IDLE) & in_valid;

  div_bus_sequencer_reg #(.W(DATA_W)) u_a_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (req_load),
    .shift_en (1'b0),
    .shift_in (1'b0),
    .d        (dividend[2*DATA_W-1:DATA_W]),
    .q        (a_q)
  );

  div_bus_sequencer_reg #(.W(DATA_W)) u_q_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (req_load),
    .shift_en (1'b0),
    .shift_in (1'b0),
    .d        (dividend[DATA_W-1:0]),
    .q        (q_q)
  );

  div_bus_sequencer_reg #(.W(DATA_W)) u_m_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (req_load),
    .shift_en (1'b0),
    .shift_in (1'b0),
    .d        (divisor),
    .q        (m_q)
  );

  // result capture selects: divider bus, or the zero-divisor bypass
  always_comb begin
    rem_load = (state == WAIT) & div_done;
    rem_d    = div_outbus;
    quo_load = (state == CAP_Q);
    quo_d    = div_outbus;
`ifdef DIVSEQ_DIV0_CHECK_EN
    if (state == CAP_R) begin
      rem_load = 1'b1;
      rem_d    = q_q;
      quo_load = 1'b1;
      quo_d    = DATA_W'(DIV0_QUOTIENT);
    end
`endif
  end

  div_bus_sequencer_reg #(.W(DATA_W)) u_rem_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (rem_load),
    .shift_en (1'b0),
    .shift_in (1'b0),
    .d        (rem_d),
    .q        (remainder)
  );

  div_bus_sequencer_reg #(.W(DATA_W)) u_quo_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (quo_load),
    .shift_en (1'b0),
    .shift_in (1'b0),
    .d        (quo_d),
    .q        (quotient)
  );

  // sequencer FSM; bus and strobes are registered one state ahead
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_enable <= 1'b0;
      div_inbus  <= '0;
      out_valid  <= 1'b0;
`ifdef DIVSEQ_DIV0_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      div_enable <= 1'b0;
      div_inbus  <= '0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef DIVSEQ_DIV0_CHECK_EN
            err_q <= 1'b0;
            if (div0) begin
              state <= CAP_R;
            end else begin
              state      <= START;
              div_enable <= 1'b1;
            end
`else
            state      <= START;
            div_enable <= 1'b1;
`endif
          end
        end
        START: begin
          state     <= LOAD_A;
          div_inbus <= a_q;
        end
        LOAD_A: begin
          state     <= LOAD_Q;
          div_inbus <= q_q;
        end
        LOAD_Q: begin
          state     <= LOAD_M;
          div_inbus <= m_q;
        end
        LOAD_M: begin
          state <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            state <= CAP_Q;
          end
        end
        CAP_R: begin
          state     <= RESULT;
          out_valid <= 1'b1;
`ifdef DIVSEQ_DIV0_CHECK_EN
          err_q     <= 1'b1;
`endif
        end
        CAP_Q: begin
          state     <= RESULT;
          out_valid <= 1'b1;
        end
        RESULT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_bus_sequencer.sv
// tb_div_bus_sequencer: directed checks of the divider bus sequencer.
// Bench plays the divider with hand-computed responses.
module tb_div_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_err;
  logic        busy;
  logic        div_enable;
  logic [7:0]  div_inbus;
  logic        div_done = 1'b0;
  logic [7:0]  div_outbus = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_bus_sequencer #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_err    (div_err),
    .busy       (busy),
    .div_enable (div_enable),
    .div_inbus  (div_inbus),
    .div_done   (div_done),
    .div_outbus (div_outbus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // present a request at a negedge; returns just after the accepting edge
  task automatic send(input logic [15:0] dd, input logic [7:0] dv);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 8'hBE;
  endtask

  // full transfer: bus words, divider response, captured result
  task automatic run(input logic [15:0] dd, input logic [7:0] dv,
                     input logic [7:0] q, input logic [7:0] r,
                     input int lat, input bit spurious);
    send(dd, dv);
    @(negedge clk);
    chk("enable_pulse", div_enable, 1);
    chk("bus_start", div_inbus, 0);
    chk("err_cleared", div_err, 0);
    @(negedge clk);
    chk("bus_a", div_inbus, dd[15:8]);
    chk("enable_off", div_enable, 0);
    @(negedge clk);
    chk("bus_q", div_inbus, dd[7:0]);
    @(negedge clk);
    chk("bus_m", div_inbus, dv);
    if (spurious) begin
      div_done   = 1'b1;
      div_outbus = 8'hAA;
    end
    @(negedge clk);
    div_done   = 1'b0;
    div_outbus = '0;
    chk("bus_wait", div_inbus, 0);
    chk("busy_wait", busy, 1);
    chk("ov_wait", out_valid, 0);
    repeat (lat) @(negedge clk);
    div_done   = 1'b1;
    div_outbus = r;
    @(negedge clk);
    div_done   = 1'b0;
    div_outbus = q;
    chk("ov_capq", out_valid, 0);
    @(negedge clk);
    div_outbus = '0;
    chk("ov_result", out_valid, 1);
    chk("quotient", quotient, q);
    chk("remainder", remainder, r);
    chk("err_normal", div_err, 0);
  endtask

  // hold the result for some cycles, then handshake it away
  task automatic consume(input int hold, input logic [7:0] q,
                         input logic [7:0] r, input bit poke);
    out_ready = 1'b0;
    if (poke) begin
      in_valid = 1'b1;
      dividend = 16'h0101;
      divisor  = 8'h01;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_ov", out_valid, 1);
      chk("hold_q", quotient, q);
      chk("hold_r", remainder, r);
      chk("hold_ready", in_ready, 0);
      chk("hold_busy", busy, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("done_ov", out_valid, 0);
    chk("done_ready", in_ready, 1);
    chk("done_busy", busy, 0);
    chk("keep_q", quotient, q);
    chk("keep_r", remainder, r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_en", div_enable, 0);
    chk("rst_bus", div_inbus, 0);
    chk("rst_busy", busy, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);

    // 100 / 7 = 14 r 2
    run(16'h0064, 8'h07, 8'h0E, 8'h02, 3, 1'b0);
    consume(0, 8'h0E, 8'h02, 1'b0);

    // held result, with ignored request during RESULT
    run(16'h0123, 8'h45, 8'h04, 8'h0F, 1, 1'b0);
    consume(10, 8'h04, 8'h0F, 1'b1);

    // back-to-back: 42/5 = 8 r 2, then 255/16 = 15 r 15
    run(16'h002A, 8'h05, 8'h08, 8'h02, 0, 1'b0);
    consume(0, 8'h08, 8'h02, 1'b0);
    run(16'h00FF, 8'h10, 8'h0F, 8'h0F, 2, 1'b0);
    consume(0, 8'h0F, 8'h0F, 1'b0);

    // spurious done during LOAD_M: 200/10 = 20 r 0
    run(16'h00C8, 8'h0A, 8'h14, 8'h00, 4, 1'b1);
    consume(1, 8'h14, 8'h00, 1'b0);

    // reset while in LOAD_Q
    send(16'h0064, 8'h07);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_bus", div_inbus, 8'h64);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", div_enable, 0);
    chk("mid_rst_bus", div_inbus, 0);
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_q", quotient, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", in_ready, 1);
    run(16'h0064, 8'h07, 8'h0E, 8'h02, 1, 1'b0);
    consume(0, 8'h0E, 8'h02, 1'b0);

`ifdef DIVSEQ_DIV0_CHECK_EN
    send(16'h0033, 8'h00);
    @(negedge clk);
    chk("d0_en1", div_enable, 0);
    chk("d0_ov1", out_valid, 0);
    @(negedge clk);
    chk("d0_en2", div_enable, 0);
    chk("d0_ov2", out_valid, 1);
    chk("d0_q", quotient, 8'hFF);
    chk("d0_r", remainder, 8'h33);
    chk("d0_err", div_err, 1);
    consume(0, 8'hFF, 8'h33, 1'b0);
    chk("d0_err_kept", div_err, 1);
    run(16'h002A, 8'h05, 8'h08, 8'h02, 0, 1'b0);
    consume(0, 8'h08, 8'h02, 1'b0);
`else
    run(16'h0033, 8'h00, 8'hFF, 8'h33, 1, 1'b0);
    consume(0, 8'hFF, 8'h33, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
